// File: rtl/adder_pkg.sv
// Shared types and helpers for the chunked serial adder.
// Holds the FSM state encoding and the signed-overflow rule.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // Two's-complement overflow: operands agree in sign, sum does not.
    function automatic logic calc_ovf(
        input logic a_msb,
        input logic b_msb,
        input logic s_msb
    );
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational N-bit adder slice with carry in/out.
// Ports: x, y (N-bit addends), ci (carry in), s (N-bit sum), co (carry out).
module chunk_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         ci,
    output logic [N-1:0] s,
    output logic         co
);

    assign {co, s} = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, ci};

endmodule

// File: rtl/chunked_serial_adder.sv
// Multi-cycle WIDTH-bit adder, CHUNK bits per clock, valid/ready on both sides.
// Ports: clk, rst (async high), in_valid/in_ready/a/b/cin, out_valid/out_ready/sum/cout/ovf.
module chunked_serial_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    // Guarded so a bad CHUNK reports cleanly instead of dividing by zero.
    localparam int CHUNK_SAFE = (CHUNK < 1) ? 1 : CHUNK;
    localparam int NCHUNK     = WIDTH / CHUNK_SAFE;
    localparam int CW         = $clog2(NCHUNK + 1);
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    generate
        if (CHUNK < 1 || (WIDTH % CHUNK_SAFE) != 0) begin : g_bad_cfg
            $error("chunked_serial_adder: CHUNK must be >= 1 and divide WIDTH");
        end
    endgenerate

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic             r_carry;
    logic             r_amsb;
    logic             r_bmsb;
    logic [CW-1:0]    r_cnt;

    logic [CHUNK_SAFE-1:0] w_s;
    logic                  w_co;
    logic [WIDTH-1:0]      w_sum_next;

    chunk_adder #(
        .N(CHUNK_SAFE)
    ) u_chunk (
        .x (r_a[CHUNK_SAFE-1:0]),
        .y (r_b[CHUNK_SAFE-1:0]),
        .ci(r_carry),
        .s (w_s),
        .co(w_co)
    );

    // New chunk enters at the top; after NCHUNK steps the
    // first chunk has reached bit 0.
    assign w_sum_next = (r_sum >> CHUNK_SAFE)
                      | (WIDTH'(w_s) << (WIDTH - CHUNK_SAFE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = BUSY;
                end
            end
            BUSY: begin
                if (r_cnt == LAST) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
            r_amsb  <= 1'b0;
            r_bmsb  <= 1'b0;
            r_cnt   <= '0;
        end else if (r_state == IDLE && in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_amsb  <= a[WIDTH-1];
            r_bmsb  <= b[WIDTH-1];
            r_cnt   <= '0;
        end else if (r_state == BUSY) begin
            r_a     <= r_a >> CHUNK_SAFE;
            r_b     <= r_b >> CHUNK_SAFE;
            r_sum   <= w_sum_next;
            r_carry <= w_co;
            r_cnt   <= r_cnt + CW'(1);
        end
    end

    assign sum  = r_sum;
    assign cout = r_carry;
    assign ovf  = calc_ovf(r_amsb, r_bmsb, r_sum[WIDTH-1]);

endmodule

// File: tb/tb_chunked_serial_adder.sv
// Scoreboard bench for chunked_serial_adder at CHUNK = 8, 32 and 1.
// Drivers push expected results; a monitor pops on every output handshake.
module tb_chunked_serial_adder;

    typedef struct {
        int          id;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [31:0] a         [3];
    logic [31:0] b         [3];
    logic        cin       [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [31:0] sum       [3];
    logic        cout      [3];
    logic        ovf       [3];

    exp_t q[$];
    int   n_total = 0;
    int   n_pass  = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        chunked_serial_adder #(
            .WIDTH(32),
            .CHUNK((g == 0) ? 8 : (g == 1) ? 32 : 1)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .in_valid (in_valid[g]),
            .in_ready (in_ready[g]),
            .a        (a[g]),
            .b        (b[g]),
            .cin      (cin[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .sum      (sum[g]),
            .cout     (cout[g]),
            .ovf      (ovf[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Monitor: a result leaves on the edge after valid&&ready is seen here.
    always @(negedge clk) begin : mon
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            if (!rst && out_valid[k] && out_ready[k]) begin
                if (q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_result: dut %0d sum %h expected none",
                             k, sum[k]);
                end else begin
                    e = q.pop_front();
                    chk("result_dut", k, e.id);
                    chk("sum", sum[k], e.sum);
                    chk("cout", cout[k], e.cout);
                    chk("ovf", ovf[k], e.ovf);
                end
            end
        end
    end

    task automatic push(input int k, input logic [31:0] s,
                        input logic c, input logic o);
        exp_t e;
        e.id = k; e.sum = s; e.cout = c; e.ovf = o;
        q.push_back(e);
    endtask

    task automatic wait_valid(input int k, input int lat);
        int n = 0;
        while (!out_valid[k] && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", n, lat);
    endtask

    task automatic wait_pop(input int k);
        int n = 0;
        while (out_valid[k] && n < 200) begin
            @(posedge clk); #1; n++;
        end
        chk("popped", out_valid[k], 0);
    endtask

    task automatic run_op(input int k, input logic [31:0] av,
                          input logic [31:0] bv, input logic ci,
                          input logic [31:0] es, input logic ec,
                          input logic eo, input int lat);
        @(negedge clk);
        a[k] = av; b[k] = bv; cin[k] = ci; in_valid[k] = 1'b1;
        chk("in_ready_idle", in_ready[k], 1);
        push(k, es, ec, eo);
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
        a[k] = ~av; b[k] = 32'hDEAD_BEEF; cin[k] = ~ci;
        wait_valid(k, lat);
        wait_pop(k);
    endtask

    initial begin
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid[k] = 1'b0; out_ready[k] = 1'b1;
            a[k] = '0; b[k] = '0; cin[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready[0], 1);
        chk("rst_out_valid", out_valid[0], 0);
        chk("rst_sum", sum[0], 0);
        chk("rst_cout", cout[0], 0);
        chk("rst_ovf", ovf[0], 0);
        rst = 1'b0;

        run_op(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 4);
        run_op(0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 4);
        run_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 4);
        run_op(0, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 4);

        // Backpressure with a new request already waiting.
        out_ready[0] = 1'b0;
        @(negedge clk);
        a[0] = 32'h1234_5678; b[0] = 32'h1111_1111; cin[0] = 1'b0;
        in_valid[0] = 1'b1;
        push(0, 32'h2345_6789, 1'b0, 1'b0);
        @(posedge clk); #1;
        a[0] = 32'd5; b[0] = 32'd7;
        wait_valid(0, 4);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("bp_out_valid", out_valid[0], 1);
            chk("bp_in_ready", in_ready[0], 0);
            chk("bp_sum", sum[0], 32'h2345_6789);
            chk("bp_cout", cout[0], 0);
            chk("bp_ovf", ovf[0], 0);
        end
        @(posedge clk); #1;
        out_ready[0] = 1'b1;
        push(0, 32'd12, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("after_pop_in_ready", in_ready[0], 1);
        chk("after_pop_out_valid", out_valid[0], 0);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        chk("accepted_held_req", in_ready[0], 0);
        wait_valid(0, 4);
        wait_pop(0);

        // Reset in the 2nd BUSY cycle; no result may emerge.
        @(negedge clk);
        a[0] = 32'hFFFF_FFFF; b[0] = 32'h1; cin[0] = 1'b0; in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid[0], 0);
        chk("midrst_in_ready", in_ready[0], 1);
        chk("midrst_sum", sum[0], 0);
        chk("midrst_cout", cout[0], 0);
        #1;
        rst = 1'b0;
        run_op(0, 32'd3, 32'd4, 1'b0, 32'd7, 1'b0, 1'b0, 4);

        // CHUNK = WIDTH
        run_op(1, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0, 1);
        run_op(1, 32'h7FFF_FFFF, 32'h1, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1);
        // CHUNK = 1
        run_op(2, 32'hFFFF_FFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0, 32);
        run_op(2, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0, 1'b1, 1'b1, 32);
        run_op(2, 32'h0000_00FF, 32'h1, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 32);

        for (int i = 0; i < 50 && q.size() != 0; i++) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/chunked_serial_adder.md
# chunked_serial_adder

Parametrised multi-cycle adder that sums two WIDTH-bit operands plus a carry-in, CHUNK bits per clock, through one shared carry register. It produces sum, carry-out and signed overflow behind a valid/ready handshake. It is the sequential, width-generic successor to the single-bit full adder, for datapaths that trade latency for area. It sits between an operand producer and a result consumer, both using valid/ready.

## Interface
Parameters:
- WIDTH, 32: operand and sum width in bits.
- CHUNK, 8: bits added per cycle. Must be ≥1 and divide WIDTH exactly; elaboration fails otherwise.
- NCHUNK (localparam) = WIDTH/CHUNK: cycles per addition.

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands a, b, cin are valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in to bit 0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes the result.
- sum  out  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  two's-complement signed overflow.

## Operation
- FSM with three states: IDLE, BUSY, DONE. The reset state is IDLE.
- **IDLE**
  - in_ready=1, out_valid=0.
  - When in_valid is high at an edge:
    - latch a and b into shift registers;
    - carry register ← cin;
    - store a[WIDTH-1] and b[WIDTH-1];
    - chunk counter ← 0;
    - next state BUSY.
- **BUSY**
  - in_ready=0, out_valid=0.
  - Each edge: the low CHUNK bits of both shift registers plus the carry go through chunk_adder.
  - The CHUNK-bit result enters the top of the sum register, which shifts right by CHUNK.
  - Operand registers shift right by CHUNK; carry ← chunk carry-out; counter increments.
  - At the edge where counter = NCHUNK-1, next state is DONE.
- **DONE**
  - out_valid=1, in_ready=0.
  - sum, cout and ovf are held stable.
  - When out_ready is high at an edge, next state is IDLE.
- Result rules:
  - cout = final carry register value.
  - ovf = (a_msb == b_msb) && (sum[WIDTH-1] != a_msb), using the stored operand MSBs.
- Operands are captured only at the accept edge. Changes on a, b or cin afterwards have no effect.
- in_valid while BUSY or DONE is ignored. The producer holds it until in_ready is high.
- sum/cout/ovf are defined only while out_valid=1. Their values in other states are unspecified but deterministic.

## Timing
- Reset (asynchronous, active-high):
  - state=IDLE, in_ready=1, out_valid=0;
  - sum=0, cout=0, ovf=0, carry=0, counter=0.
  - Reset mid-BUSY or mid-DONE discards the operation. No carry or partial sum survives.
- Latency: accept at edge T → out_valid high after edge T+NCHUNK.
  - With CHUNK=WIDTH this is one cycle of BUSY.
- Throughput:
  - one result per NCHUNK+2 cycles when out_ready is held high;
  - in_ready rises the cycle after the DONE pop.
- Backpressure: while out_ready=0 in DONE, all outputs stay unchanged indefinitely.
- A DONE→IDLE pop and a new accept never share an edge, because in_ready=0 in DONE.
- Carry wrap: the final carry becomes cout. Nothing is fed back into the next operation; each operation reloads carry from cin.

## Structure
- Shared package adder_pkg holds:
  - typedef enum logic [1:0] {IDLE, BUSY, DONE} for the FSM state;
  - a function computing ovf from the two operand MSBs and the sum MSB.
- One combinational sub-module, chunk_adder:
  - parameter N;
  - inputs x[N], y[N], ci;
  - outputs s[N], co.
  - Instantiated once with N=CHUNK.
- The top level holds the FSM, counter (width $clog2(NCHUNK+1)), operand/sum shift registers, carry register and MSB registers.

## Test plan
All scenarios use WIDTH=32, CHUNK=8 unless noted.
- **Chunk-boundary carry:** a=0x0000_00FF, b=0x0000_0001, cin=0 → sum=0x0000_0100, cout=0, ovf=0; out_valid exactly 4 cycles after the accept edge.
- **Full ripple through every chunk:** a=0xFFFF_FFFF, b=0, cin=1 → sum=0, cout=1, ovf=0.
- **Signed overflow, positive:** a=0x7FFF_FFFF, b=1, cin=0 → sum=0x8000_0000, cout=0, ovf=1.
- **Signed overflow, negative:** a=0x8000_0000, b=0x8000_0000 → sum=0, cout=1, ovf=1.
- **Backpressure and input isolation:**
  - hold out_ready=0 for 6 cycles after out_valid, with in_valid=1 and new operands a=5, b=7 applied;
  - outputs unchanged and in_ready=0 throughout;
  - after the pop, in_ready rises one cycle later, a=5, b=7 is accepted, and sum=12.
- **Reset mid-operation:**
  - start a=0xFFFF_FFFF, b=1; pulse rst asynchronously during the 2nd BUSY cycle;
  - out_valid=0 and in_ready=1 immediately;
  - next op a=3, b=4, cin=0 → sum=7, cout=0, with no leaked carry.
- **Degenerate configurations:**
  - WIDTH=32, CHUNK=32 instance: latency 1 cycle; 0xFFFF_FFFF+1 → sum=0, cout=1.
  - CHUNK=1 instance: latency 32 cycles, same results.
